// File: rtl/pong_game_controller.sv
// Match sequencer for the Pong datapath: owns game state, scores and winner,
// and drives pause / ball_reset / serve direction into img_generator.
module pong_game_controller #(
    parameter int unsigned SERVE_DELAY = 50,
    parameter int unsigned POINT_HOLD  = 25,
    parameter int unsigned WIN_SCORE   = 7,
    parameter logic [3:0]  START_KEY   = 4'd1,
    parameter logic [3:0]  PAUSE_KEY   = 4'd4
) (
    input  logic       CLOCK_25,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] keys_1,
    input  logic [3:0] keys_2,
    input  logic       miss_1,
    input  logic       miss_2,
    output logic       pause,
    output logic       ball_reset,
    output logic       serve_left,
    output logic [2:0] score_1,
    output logic [2:0] score_2,
    output logic [1:0] winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        HOLD      = 3'd3,
        POINT     = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam logic [7:0] SERVE_CNT = 8'(SERVE_DELAY);
    localparam logic [7:0] POINT_CNT = 8'(POINT_HOLD);
    localparam logic [2:0] WIN       = 3'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] prev_1_q, prev_2_q;
    logic [2:0] score_1_d, score_2_d;
    logic [1:0] winner_d;
    logic       serve_left_d;
    logic       start_press, pause_press;

    function automatic logic [2:0] sat_inc(input logic [2:0] s);
        return (s == 3'd7) ? 3'd7 : s + 3'd1;
    endfunction

    // A press is the first cycle a code appears; holding a key yields one press.
    assign start_press = (keys_1 == START_KEY && prev_1_q != START_KEY) ||
                         (keys_2 == START_KEY && prev_2_q != START_KEY);
    assign pause_press = (keys_1 == PAUSE_KEY && prev_1_q != PAUSE_KEY) ||
                         (keys_2 == PAUSE_KEY && prev_2_q != PAUSE_KEY);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        score_1_d    = score_1;
        score_2_d    = score_2;
        winner_d     = winner;
        serve_left_d = serve_left;
        case (state_q)
            IDLE: begin
                if (start_press) state_d = SERVE;
            end
            SERVE: begin
                if (tick) begin
                    if (cnt_q == 8'd1) state_d = PLAY;
                    else               cnt_d   = cnt_q - 8'd1;
                end
            end
            PLAY: begin
                if (miss_1 && miss_2) begin
                    state_d = POINT;
                end else if (miss_1) begin
                    score_2_d    = sat_inc(score_2);
                    serve_left_d = 1'b0;
                    if (score_2_d == WIN) begin
                        state_d  = GAME_OVER;
                        winner_d = 2'd2;
                    end else begin
                        state_d = POINT;
                    end
                end else if (miss_2) begin
                    score_1_d    = sat_inc(score_1);
                    serve_left_d = 1'b1;
                    if (score_1_d == WIN) begin
                        state_d  = GAME_OVER;
                        winner_d = 2'd1;
                    end else begin
                        state_d = POINT;
                    end
                end else if (pause_press) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (pause_press) state_d = PLAY;
            end
            POINT: begin
                if (tick) begin
                    if (cnt_q == 8'd1) state_d = SERVE;
                    else               cnt_d   = cnt_q - 8'd1;
                end
            end
            GAME_OVER: begin
                if (start_press) begin
                    state_d   = SERVE;
                    score_1_d = 3'd0;
                    score_2_d = 3'd0;
                    winner_d  = 2'd0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Entry load overrides any same-cycle tick decrement.
        if (state_d == SERVE && state_q != SERVE) cnt_d = SERVE_CNT;
        if (state_d == POINT && state_q != POINT) cnt_d = POINT_CNT;
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            prev_1_q   <= 4'd0;
            prev_2_q   <= 4'd0;
            pause      <= 1'b1;
            ball_reset <= 1'b0;
            serve_left <= 1'b0;
            score_1    <= 3'd0;
            score_2    <= 3'd0;
            winner     <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_1_q   <= keys_1;
            prev_2_q   <= keys_2;
            pause      <= (state_d != PLAY);
            ball_reset <= (state_d == SERVE) && (state_q != SERVE);
            serve_left <= serve_left_d;
            score_1    <= score_1_d;
            score_2    <= score_2_d;
            winner     <= winner_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// Bench for pong_game_controller: directed match walkthrough followed by random
// play, every cycle compared against a rule-level model of the match.
module tb_pong_game_controller;

    localparam int SD  = 3;
    localparam int PH  = 2;
    localparam int WIN = 3;

    logic       CLOCK_25 = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] keys_1 = 4'd0;
    logic [3:0] keys_2 = 4'd0;
    logic       miss_1 = 1'b0;
    logic       miss_2 = 1'b0;
    logic       pause, ball_reset, serve_left;
    logic [2:0] score_1, score_2, state;
    logic [1:0] winner;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the match in plain integers.
    int m_state, m_ticks_left, m_s1, m_s2, m_win, m_sl, m_br, m_pause, m_prev1, m_prev2;

    pong_game_controller #(
        .SERVE_DELAY(SD), .POINT_HOLD(PH), .WIN_SCORE(WIN),
        .START_KEY(4'd1), .PAUSE_KEY(4'd4)
    ) dut (
        .CLOCK_25(CLOCK_25), .reset(reset), .tick(tick),
        .keys_1(keys_1), .keys_2(keys_2), .miss_1(miss_1), .miss_2(miss_2),
        .pause(pause), .ball_reset(ball_reset), .serve_left(serve_left),
        .score_1(score_1), .score_2(score_2), .winner(winner), .state(state)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit st, pz;
        int ns;
        if (reset) begin
            m_state = 0; m_ticks_left = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
            m_sl = 0; m_br = 0; m_pause = 1; m_prev1 = 0; m_prev2 = 0;
            return;
        end
        st = (keys_1 == 1 && m_prev1 != 1) || (keys_2 == 1 && m_prev2 != 1);
        pz = (keys_1 == 4 && m_prev1 != 4) || (keys_2 == 4 && m_prev2 != 4);
        m_prev1 = keys_1;
        m_prev2 = keys_2;
        ns = m_state;
        if (m_state == 0) begin
            if (st) ns = 1;
        end else if (m_state == 1 || m_state == 4) begin
            if (tick) begin
                m_ticks_left--;
                if (m_ticks_left == 0) ns = (m_state == 1) ? 2 : 1;
            end
        end else if (m_state == 2) begin
            if (miss_1 && miss_2) ns = 4;
            else if (miss_1) begin
                m_s2 = (m_s2 < 7) ? m_s2 + 1 : 7;
                m_sl = 0;
                if (m_s2 == WIN) begin ns = 5; m_win = 2; end else ns = 4;
            end else if (miss_2) begin
                m_s1 = (m_s1 < 7) ? m_s1 + 1 : 7;
                m_sl = 1;
                if (m_s1 == WIN) begin ns = 5; m_win = 1; end else ns = 4;
            end else if (pz) ns = 3;
        end else if (m_state == 3) begin
            if (pz) ns = 2;
        end else if (m_state == 5) begin
            if (st) begin ns = 1; m_s1 = 0; m_s2 = 0; m_win = 0; end
        end
        m_br = (ns == 1 && m_state != 1);
        if (ns == 1 && m_state != 1) m_ticks_left = SD;
        if (ns == 4 && m_state != 4) m_ticks_left = PH;
        m_state = ns;
        m_pause = (ns != 2);
    endtask

    task automatic step();
        model_step();
        @(posedge CLOCK_25);
        #1;
        check("state", state, m_state);
        check("pause", pause, m_pause);
        check("ball_reset", ball_reset, m_br);
        check("serve_left", serve_left, m_sl);
        check("score_1", score_1, m_s1);
        check("score_2", score_2, m_s2);
        check("winner", winner, m_win);
    endtask

    task automatic drive(input bit r, input bit t, input logic [3:0] k1, input logic [3:0] k2,
                         input bit a, input bit b);
        reset = r; tick = t; keys_1 = k1; keys_2 = k2; miss_1 = a; miss_2 = b;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(0, 1, 4'd0, 4'd0, 0, 0);
    endtask

    logic [3:0] key_pool [5] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8};

    initial begin
        // Reset values
        drive(1, 0, 4'd0, 4'd0, 0, 0);
        drive(1, 1, 4'd1, 4'd4, 1, 1);
        check("rst_state", state, 0);
        check("rst_pause", pause, 1);
        check("rst_ball_reset", ball_reset, 0);
        check("rst_scores", {score_1, score_2}, 0);

        // Start, serve countdown
        drive(0, 0, 4'd1, 4'd0, 0, 0);
        check("start_state", state, 1);
        check("start_ball_reset", ball_reset, 1);
        drive(0, 1, 4'd0, 4'd0, 0, 0);
        check("serve_pulse_end", ball_reset, 0);
        ticks(1);
        check("serve_still", pause, 1);
        ticks(1);
        check("play_state", state, 2);
        check("play_pause", pause, 0);

        // Point to player 2, then re-serve
        drive(0, 0, 4'd0, 4'd0, 1, 0);
        check("miss1_score2", score_2, 1);
        check("miss1_state", state, 4);
        check("miss1_serve_left", serve_left, 0);
        ticks(2);
        check("point_to_serve", state, 1);
        check("point_ball_reset", ball_reset, 1);
        ticks(3);

        // User pause held, miss in hold, release and re-press
        for (int i = 0; i < 10; i++) drive(0, 0, 4'd0, 4'd4, 0, 0);
        check("hold_state", state, 3);
        drive(0, 0, 4'd0, 4'd4, 1, 0);
        check("hold_miss_score2", score_2, 1);
        drive(0, 0, 4'd0, 4'd0, 0, 0);
        drive(0, 0, 4'd0, 4'd4, 0, 0);
        check("unhold_state", state, 2);

        // Simultaneous misses, then pause press with miss
        drive(0, 0, 4'd0, 4'd0, 1, 1);
        check("double_miss_state", state, 4);
        check("double_miss_scores", {score_1, score_2}, 1);
        ticks(2); ticks(3);
        drive(0, 0, 4'd4, 4'd0, 0, 1);
        check("pz_miss_state", state, 4);
        check("pz_miss_score1", score_1, 1);
        check("pz_miss_serve_left", serve_left, 1);
        ticks(2); ticks(3);

        // Match win for player 1
        drive(0, 0, 4'd0, 4'd0, 0, 1);
        ticks(2); ticks(3);
        drive(0, 0, 4'd0, 4'd0, 0, 1);
        check("win_score1", score_1, 3);
        check("win_winner", winner, 1);
        check("win_state", state, 5);
        check("win_pause", pause, 1);
        drive(0, 1, 4'd0, 4'd0, 1, 0);
        check("go_hold_score2", score_2, 1);
        drive(0, 0, 4'd0, 4'd1, 0, 0);
        check("restart_state", state, 1);
        check("restart_scores", {score_1, score_2}, 0);
        check("restart_winner", winner, 0);
        check("restart_serve_left", serve_left, 1);
        ticks(3);

        // Reset during POINT with counter at 1 and tick high
        drive(0, 0, 4'd0, 4'd0, 1, 0);
        ticks(1);
        drive(1, 1, 4'd0, 4'd0, 0, 0);
        check("midrst_state", state, 0);
        check("midrst_ball_reset", ball_reset, 0);
        check("midrst_score2", score_2, 0);
        drive(0, 0, 4'd0, 4'd0, 0, 0);
        check("midrst_no_pulse", ball_reset, 0);

        // Random play
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] k1, k2;
            k1 = keys_1;
            k2 = keys_2;
            if ($urandom_range(0, 3) == 0) k1 = key_pool[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) k2 = key_pool[$urandom_range(0, 4)];
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, k1, k2,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
